// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock,
// then releases core_reset_n and, STAGE_GAP cycles later, video_reset_n.
//
// Ports:
//   clk_74a         free-running reference clock (also the PLL refclk)
//   reset_n         asynchronous active-low reset
//   pll_locked      raw PLL lock flag, asynchronous to clk_74a
//   pll_rst         active-high reset to the PLL
//   pll_locked_sync pll_locked after the two-flop synchronizer
//   core_reset_n    active-low reset for the core domains
//   video_reset_n   active-low reset for the video domains
//   lock_loss_count saturating count of lock losses after release
//   state           FSM state (RESET_PLL=0 .. RUN=4)
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES = 8,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGE_GAP      = 16
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       pll_locked_sync,
    output logic       core_reset_n,
    output logic       video_reset_n,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state
);

    // One shared counter covers every timed state.
    localparam int MAX_AB  = (LOCK_TIMEOUT > STABLE_CYCLES) ?
                             LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int MAX_CD  = (PLL_RST_CYCLES > STAGE_GAP) ?
                             PLL_RST_CYCLES : STAGE_GAP;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             pll_rst_q;
    logic             core_rst_n_q;
    logic             video_rst_n_q;
    logic [7:0]       loss_q;

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_RESET_PLL;
            cnt_q         <= '0;
            pll_rst_q     <= 1'b1;
            core_rst_n_q  <= 1'b0;
            video_rst_n_q <= 1'b0;
            loss_q        <= 8'd0;
        end else begin
            unique case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= ST_WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (sync2_q) begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_q   <= ST_RESET_PLL;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    // A drop before release is not counted as a loss.
                    if (!sync2_q) begin
                        state_q <= ST_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_q      <= ST_RELEASE;
                        cnt_q        <= '0;
                        core_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                ST_RELEASE, ST_RUN: begin
                    if (!sync2_q) begin
                        // Any lock loss after release resequences from scratch.
                        state_q       <= ST_RESET_PLL;
                        cnt_q         <= '0;
                        pll_rst_q     <= 1'b1;
                        core_rst_n_q  <= 1'b0;
                        video_rst_n_q <= 1'b0;
                        if (loss_q != 8'hFF) begin
                            loss_q <= loss_q + 8'd1;
                        end
                    end else if (state_q == ST_RELEASE) begin
                        if (cnt_q == GAP_LAST) begin
                            state_q       <= ST_RUN;
                            cnt_q         <= '0;
                            video_rst_n_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q       <= ST_RESET_PLL;
                    cnt_q         <= '0;
                    pll_rst_q     <= 1'b1;
                    core_rst_n_q  <= 1'b0;
                    video_rst_n_q <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst         = pll_rst_q;
    assign pll_locked_sync = sync2_q;
    assign core_reset_n    = core_rst_n_q;
    assign video_reset_n   = video_rst_n_q;
    assign lock_loss_count = loss_q;
    assign state           = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Testbench for pll_reset_seq: directed scenarios plus randomized lock
// patterns compared against a dwell-time reference model.
module tb_pll_reset_seq;

    localparam int PRC = 3;
    localparam int LT  = 32;
    localparam int SC  = 8;
    localparam int SG  = 4;

    localparam int M_RST  = 0;
    localparam int M_WAIT = 1;
    localparam int M_STB  = 2;
    localparam int M_REL  = 3;
    localparam int M_RUN  = 4;

    logic       clk_74a = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       pll_locked_sync;
    logic       core_reset_n;
    logic       video_reset_n;
    logic [7:0] lock_loss_count;
    logic [2:0] state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: current mode, edges spent in it, loss count,
    // and the lock history that feeds the two-cycle input delay.
    int m_st = M_RST;
    int m_n = 0;
    int m_loss = 0;
    bit m_sync = 1'b0;
    bit lkq[$];

    pll_reset_seq #(
        .PLL_RST_CYCLES(PRC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .STAGE_GAP     (SG)
    ) dut (
        .clk_74a        (clk_74a),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .pll_rst        (pll_rst),
        .pll_locked_sync(pll_locked_sync),
        .core_reset_n   (core_reset_n),
        .video_reset_n  (video_reset_n),
        .lock_loss_count(lock_loss_count),
        .state          (state)
    );

    always #5 clk_74a = ~clk_74a;

    function automatic logic [15:0] dut_vec();
        return {state, pll_rst, core_reset_n, video_reset_n,
                lock_loss_count, pll_locked_sync};
    endfunction

    function automatic logic [15:0] mdl_vec();
        logic [2:0] s3;
        s3 = 3'(m_st);
        return {s3, (m_st == M_RST), (m_st >= M_REL), (m_st == M_RUN),
                8'(m_loss), m_sync};
    endfunction

    task automatic model_reset();
        m_st = M_RST;
        m_n = 0;
        m_loss = 0;
        m_sync = 1'b0;
        lkq.delete();
        cyc = 0;
    endtask

    task automatic model_edge(input bit lk);
        bit s;
        s = m_sync;
        lkq.push_back(lk);
        if (lkq.size() > 2) void'(lkq.pop_front());
        m_sync = (lkq.size() >= 2) ? lkq[lkq.size()-2] : 1'b0;
        m_n++;
        case (m_st)
            M_RST: if (m_n == PRC) begin m_st = M_WAIT; m_n = 0; end
            M_WAIT: begin
                if (s) begin m_st = M_STB; m_n = 0; end
                else if (m_n == LT) begin m_st = M_RST; m_n = 0; end
            end
            M_STB: begin
                if (!s) begin m_st = M_WAIT; m_n = 0; end
                else if (m_n == SC) begin m_st = M_REL; m_n = 0; end
            end
            default: begin
                if (!s) begin
                    m_st = M_RST;
                    m_n = 0;
                    if (m_loss < 255) m_loss++;
                end else if (m_st == M_REL && m_n == SG) begin
                    m_st = M_RUN;
                    m_n = 0;
                end
            end
        endcase
    endtask

    task automatic step(input bit lk);
        pll_locked = lk;
        @(posedge clk_74a);
        model_edge(lk);
        cyc++;
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        pll_locked = 1'b0;
        model_reset();
        @(posedge clk_74a); #1;
        @(posedge clk_74a); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pll_locked = 1'b1;
        model_reset();
        @(posedge clk_74a); #1;
        @(posedge clk_74a); #1;
        vectors += 6;
        if (state !== 3'd0) begin miscompares++;
            $display("FAIL rst_state got=%0d exp=0", state); end
        if (pll_rst !== 1'b1) begin miscompares++;
            $display("FAIL rst_pll_rst got=%b exp=1", pll_rst); end
        if (core_reset_n !== 1'b0) begin miscompares++;
            $display("FAIL rst_core got=%b exp=0", core_reset_n); end
        if (video_reset_n !== 1'b0) begin miscompares++;
            $display("FAIL rst_video got=%b exp=0", video_reset_n); end
        if (lock_loss_count !== 8'd0) begin miscompares++;
            $display("FAIL rst_loss got=%0d exp=0", lock_loss_count); end
        if (pll_locked_sync !== 1'b0) begin miscompares++;
            $display("FAIL rst_sync got=%b exp=0", pll_locked_sync); end
        pll_locked = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic test_powerup();
        int rst_low = -1;
        int stb_at = -1;
        int core_at = -1;
        int vid_at = -1;
        apply_reset();
        vectors++;
        if (pll_rst !== 1'b1) begin miscompares++;
            $display("FAIL pu_rst_c0 got=%b exp=1", pll_rst); end
        for (int e = 1; e <= 30; e++) begin
            step(e >= 10);
            vectors++;
            if (dut_vec() !== mdl_vec()) begin miscompares++;
                $display("FAIL pu_model cyc=%0d got=%h exp=%h",
                         cyc, dut_vec(), mdl_vec()); end
            if (rst_low < 0 && pll_rst == 1'b0) rst_low = cyc;
            if (stb_at < 0 && state == 3'd2) stb_at = cyc;
            if (core_at < 0 && core_reset_n == 1'b1) core_at = cyc;
            if (vid_at < 0 && video_reset_n == 1'b1) vid_at = cyc;
        end
        vectors += 5;
        if (rst_low != PRC) begin miscompares++;
            $display("FAIL pu_rst_len got=%0d exp=%0d", rst_low, PRC); end
        if (stb_at != 12) begin miscompares++;
            $display("FAIL pu_stable got=%0d exp=12", stb_at); end
        if (core_at != 12 + SC) begin miscompares++;
            $display("FAIL pu_core got=%0d exp=%0d", core_at, 12 + SC); end
        if (vid_at != 12 + SC + SG) begin miscompares++;
            $display("FAIL pu_video got=%0d exp=%0d", vid_at, 12 + SC + SG); end
        if (lock_loss_count !== 8'd0) begin miscompares++;
            $display("FAIL pu_loss got=%0d exp=0", lock_loss_count); end
    endtask

    task automatic test_timeout();
        int ph;
        apply_reset();
        for (int e = 1; e <= 80; e++) begin
            step(1'b0);
            ph = cyc % (PRC + LT);
            vectors += 2;
            if (state !== ((ph < PRC) ? 3'd0 : 3'd1) || pll_rst !== (ph < PRC))
            begin miscompares++;
                $display("FAIL to_phase cyc=%0d got=%0d/%b", cyc, state, pll_rst);
            end
            if (core_reset_n !== 1'b0 || video_reset_n !== 1'b0) begin
                miscompares++;
                $display("FAIL to_resets cyc=%0d got=%b%b exp=00",
                         cyc, core_reset_n, video_reset_n);
            end
        end
    endtask

    task automatic test_stable_drop();
        apply_reset();
        for (int e = 1; e <= 22; e++) begin
            step(e != 8);
            vectors++;
            if (dut_vec() !== mdl_vec()) begin miscompares++;
                $display("FAIL sd_model cyc=%0d got=%h exp=%h",
                         cyc, dut_vec(), mdl_vec()); end
            if (cyc == 9 || cyc == 18) begin
                vectors++;
                if (state !== 3'd2) begin miscompares++;
                    $display("FAIL sd_stable cyc=%0d got=%0d exp=2", cyc, state);
                end
            end
            if (cyc == 10) begin
                vectors++;
                if (state !== 3'd1 || pll_rst !== 1'b0 ||
                    lock_loss_count !== 8'd0) begin miscompares++;
                    $display("FAIL sd_drop got=%0d/%b/%0d exp=1/0/0",
                             state, pll_rst, lock_loss_count);
                end
            end
            if (cyc == 19) begin
                vectors++;
                if (state !== 3'd3) begin miscompares++;
                    $display("FAIL sd_relock got=%0d exp=3", state); end
            end
        end
    endtask

    task automatic test_run_drop();
        apply_reset();
        for (int e = 1; e <= 40; e++) begin
            step(e != 20);
            vectors++;
            if (dut_vec() !== mdl_vec()) begin miscompares++;
                $display("FAIL rd_model cyc=%0d got=%h exp=%h",
                         cyc, dut_vec(), mdl_vec()); end
            if (cyc == 21) begin
                vectors++;
                if ({state, core_reset_n, video_reset_n} !== 5'b100_11) begin
                    miscompares++;
                    $display("FAIL rd_run got=%0d/%b%b exp=4/11",
                             state, core_reset_n, video_reset_n);
                end
            end
            if (cyc == 22) begin
                vectors++;
                if ({state, pll_rst, core_reset_n, video_reset_n} !== 6'b000_100 ||
                    lock_loss_count !== 8'd1) begin miscompares++;
                    $display("FAIL rd_loss got=%0d/%b%b%b/%0d exp=0/100/1",
                             state, pll_rst, core_reset_n, video_reset_n,
                             lock_loss_count);
                end
            end
            if (cyc == 38) begin
                vectors++;
                if (state !== 3'd4 || lock_loss_count !== 8'd1) begin
                    miscompares++;
                    $display("FAIL rd_reseq got=%0d/%0d exp=4/1",
                             state, lock_loss_count);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int budget;
        apply_reset();
        for (int k = 0; k < 260; k++) begin
            budget = 60;
            while (state != 3'd4 && budget > 0) begin
                step(1'b1);
                budget--;
                vectors++;
                if (dut_vec() !== mdl_vec()) begin miscompares++;
                    $display("FAIL sat_model cyc=%0d got=%h exp=%h",
                             cyc, dut_vec(), mdl_vec()); end
            end
            if (budget == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sat_timeout loss=%0d got_state=%0d exp=4",
                         k, state);
                break;
            end
            step(1'b0);
            step(1'b1);
            step(1'b1);
            vectors++;
            if (dut_vec() !== mdl_vec()) begin miscompares++;
                $display("FAIL sat_loss k=%0d got=%h exp=%h",
                         k, dut_vec(), mdl_vec()); end
        end
        vectors++;
        if (lock_loss_count !== 8'd255) begin miscompares++;
            $display("FAIL sat_final got=%0d exp=255", lock_loss_count); end
    endtask

    task automatic test_async_release();
        int budget = 40;
        apply_reset();
        while (state != 3'd3 && budget > 0) begin
            step(1'b1);
            budget--;
        end
        step(1'b1);
        vectors++;
        if (state !== 3'd3) begin miscompares++;
            $display("FAIL ar_reach got=%0d exp=3", state); end
        #3;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({state, pll_rst, core_reset_n, video_reset_n,
             lock_loss_count, pll_locked_sync} !== 15'b000_100_00000000_0) begin
            miscompares++;
            $display("FAIL ar_async got=%0d/%b%b%b/%0d/%b exp=0/100/0/0",
                     state, pll_rst, core_reset_n, video_reset_n,
                     lock_loss_count, pll_locked_sync);
        end
        model_reset();
        pll_locked = 1'b0;
        @(posedge clk_74a); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int run_left = 0;
        bit cur = 1'b0;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                cur = ($urandom_range(0, 3) != 0);
                run_left = cur ? $urandom_range(1, 60) : $urandom_range(1, 6);
            end
            run_left--;
            step(cur);
            vectors++;
            if (dut_vec() !== mdl_vec()) begin miscompares++;
                $display("FAIL rnd_model cyc=%0d got=%h exp=%h",
                         cyc, dut_vec(), mdl_vec()); end
            vectors++;
            if (video_reset_n && !core_reset_n) begin miscompares++;
                $display("FAIL rnd_order cyc=%0d got=%b%b exp=core>=video",
                         cyc, core_reset_n, video_reset_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_timeout();
        test_stable_drop();
        test_run_drop();
        test_saturation();
        test_async_release();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
